aes_cbc_stream_enc: RTL

//  Upstream/downstream wrapper for the combinational AES-256 encrypt core (128-bit in/out).

---
 rtl/aes_cbc_stream_enc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aes_cbc_stream_enc.sv
// AES-256 CBC stream wrapper: packs DW-bit plaintext words into 128-bit blocks,
// XORs each block with the chain value, feeds the external combinational core and
// returns the registered ciphertext over a valid/ready stream.
module aes_cbc_stream_enc #(
  parameter  int DW = 32,
  localparam int NW = 128 / DW,
  localparam int CW = $clog2(NW) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [127:0]  iv_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          in_ready_o,
  output logic [127:0]  aes_pt_o,
  input  logic [127:0]  aes_ct_i,
  output logic          out_valid_o,
  output logic [127:0]  out_data_o,
  output logic          out_last_o,
  output logic [CW-1:0] out_nwords_o,
  input  logic          out_ready_i,
  output logic          busy_o
);

  // state | meaning
  // IDLE  | waiting for start; chain loaded from iv on start
  // FILL  | accepting plaintext words into the block buffer
  // ENC   | one cycle for the combinational core to settle
  // OUT   | ciphertext block presented downstream until accepted
  typedef enum logic [1:0] {IDLE, FILL, ENC, OUT} state_t;

  state_t        state_q, state_d;
  logic [127:0]  chain_q;
  logic [127:0]  blk_q;
  logic [127:0]  blk_w;
  logic [127:0]  aes_pt_q;
  logic [127:0]  out_data_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] nwords_q;
  logic          last_q;
  logic          close_w;

  // block closes on the final slot or when the message ends early
  assign close_w = (cnt_q == CW'(NW - 1)) || in_last_i;

  // current word merged into its MS-first slot; unfilled slots stay zero
  always_comb begin
    blk_w = blk_q;
    for (int i = 0; i < NW; i++) begin
      if (cnt_q == CW'(i)) blk_w[(NW-1-i)*DW +: DW] = in_data_i;
    end
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = FILL;
      FILL: if (in_valid_i && close_w) state_d = ENC;
      ENC:  state_d = OUT;
      OUT:  if (out_ready_i) state_d = last_q ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready_o  = (state_q == FILL);
    out_valid_o = (state_q == OUT);
    busy_o      = (state_q != IDLE);
  end

  // datapath: block packing, chain update and output capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q    <= '0;
      blk_q      <= '0;
      aes_pt_q   <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      nwords_q   <= '0;
      last_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            chain_q <= iv_i;
            cnt_q   <= '0;
            blk_q   <= '0;
          end
        end
        FILL: begin
          if (in_valid_i) begin
            if (close_w) begin
              aes_pt_q <= blk_w ^ chain_q;
              nwords_q <= cnt_q + CW'(1);
              last_q   <= in_last_i;
              cnt_q    <= '0;
              blk_q    <= '0;
            end else begin
              blk_q <= blk_w;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ENC: begin
          out_data_q <= aes_ct_i;
          chain_q    <= aes_ct_i;
        end
        OUT: begin
          if (out_ready_i) cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign aes_pt_o     = aes_pt_q;
  assign out_data_o   = out_data_q;
  assign out_last_o   = last_q;
  assign out_nwords_o = nwords_q;

endmodule
